// File: rtl/vme_cmd_sequencer_if.sv
// VME command-path handshake between the sequencer (master) and the VME decode block (slave).
interface vme_cmd_sequencer_if;
    logic        cmd_rd;
    logic        start;
    logic [31:0] vme_cmd_reg;
    logic [31:0] vme_dat_reg_in;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;

    modport master (
        input  cmd_rd, vme_dat_wr, vme_dat_reg_out,
        output start, vme_cmd_reg, vme_dat_reg_in
    );
    modport slave (
        output cmd_rd, vme_dat_wr, vme_dat_reg_out,
        input  start, vme_cmd_reg, vme_dat_reg_in
    );
endinterface

// File: rtl/vme_cmd_sequencer.sv
// Replays a loaded read/write command list onto the VME command path and queues read results.
// Optional WAIT timeout is built only when VME_SEQ_TIMEOUT_EN is defined.
module vme_cmd_sequencer #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AW        = 6,
    parameter int unsigned DW        = 16,
    parameter int unsigned RES_DEPTH = 16,
    parameter int unsigned RAW       = 4,
    parameter logic [31:0] MASK      = 32'h00A8_0000,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_we,
    input  logic [AW-1:0]        ld_addr,
    input  logic [1:0]           ld_op,
    input  logic [15:0]          ld_cmd,
    input  logic [DW-1:0]        ld_data,
    input  logic                 go,
    input  logic                 abort,
    input  logic                 loop_en,
    output logic                 busy,
    output logic                 done,
    vme_cmd_sequencer_if.master  vme,
    output logic                 res_valid,
    output logic [15+DW:0]       res_data,
    input  logic                 res_rd,
    output logic [RAW:0]         res_count,
    output logic                 ovf_err,
    output logic                 timeout_err
);
    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_END = 2'b11} op_e;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_FIN} state_e;

    op_e           op_mem   [DEPTH];
    logic [15:0]   cmd_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    op_e           op_q;
    logic [15:0]   cmd_q;
    logic [DW-1:0] data_q;
    logic          busy_q, done_q, start_q, ovf_q;
    logic [31:0]   cmd_reg_q, dat_in_q;
    logic          ptr_last;

    logic [15+DW:0] res_mem [RES_DEPTH];
    logic [RAW-1:0] wr_ptr_q, rd_ptr_q;
    logic [RAW:0]   cnt_q;
    logic           push_req, push, pop, full, drop;

`ifdef VME_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_err_q;
`endif

    // Memories carry no reset so they map onto RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ld_we && !busy_q) begin
            op_mem[ld_addr]   <= op_e'(ld_op);
            cmd_mem[ld_addr]  <= ld_cmd;
            data_mem[ld_addr] <= ld_data;
        end
        if (state_q == S_FETCH) begin
            op_q   <= op_mem[ptr_q];
            cmd_q  <= cmd_mem[ptr_q];
            data_q <= data_mem[ptr_q];
        end
        if (push) begin
            res_mem[wr_ptr_q] <= {cmd_q, vme.vme_dat_reg_out[DW-1:0]};
        end
    end

    assign ptr_last = (ptr_q == AW'(DEPTH - 1));

    // Advancing past the last entry is treated as END, hence done on ptr_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            ovf_q     <= 1'b0;
            cmd_reg_q <= MASK;
            dat_in_q  <= '0;
`ifdef VME_SEQ_TIMEOUT_EN
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
`endif
        end else begin
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            cmd_reg_q <= MASK;
            dat_in_q  <= '0;
            if (drop) ovf_q <= 1'b1;
            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: if (go) begin
                        state_q <= S_FETCH;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
`ifdef VME_SEQ_TIMEOUT_EN
                        tmo_err_q <= 1'b0;
`endif
                    end
                    S_FETCH: state_q <= S_DECODE;
                    S_DECODE: begin
                        unique case (op_q)
                            OP_END: begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                            end
                            OP_NOP: begin
                                state_q <= ptr_last ? S_FIN : S_FETCH;
                                ptr_q   <= ptr_q + 1'b1;
                                done_q  <= ptr_last;
                            end
                            default: state_q <= S_ISSUE;
                        endcase
                    end
                    S_ISSUE: if (vme.cmd_rd) begin
                        start_q   <= 1'b1;
                        cmd_reg_q <= MASK | {16'h0000, cmd_q} |
                                     ((op_q == OP_READ) ? 32'h0200_0000 : 32'h0100_0000);
                        dat_in_q  <= (op_q == OP_WRITE) ? 32'(data_q) : '0;
                        state_q   <= S_WAIT;
`ifdef VME_SEQ_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (vme.vme_dat_wr) begin
                            state_q <= ptr_last ? S_FIN : S_FETCH;
                            ptr_q   <= ptr_q + 1'b1;
                            done_q  <= ptr_last;
                        end
`ifdef VME_SEQ_TIMEOUT_EN
                        else if (tmo_q == TW'(TIMEOUT - 1)) begin
                            tmo_err_q <= 1'b1;
                            state_q   <= ptr_last ? S_FIN : S_FETCH;
                            ptr_q     <= ptr_q + 1'b1;
                            done_q    <= ptr_last;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
`endif
                    end
                    S_FIN: begin
                        if (loop_en) begin
                            ptr_q   <= '0;
                            state_q <= S_FETCH;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        push_req = (state_q == S_WAIT) && vme.vme_dat_wr && (op_q == OP_READ) && !abort;
        pop      = res_rd && (cnt_q != '0);
        full     = (cnt_q == (RAW + 1)'(RES_DEPTH));
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign vme.start          = start_q;
    assign vme.vme_cmd_reg    = cmd_reg_q;
    assign vme.vme_dat_reg_in = dat_in_q;
    assign res_valid          = (cnt_q != '0);
    assign res_data           = res_mem[rd_ptr_q];
    assign res_count          = cnt_q;
    assign ovf_err            = ovf_q;
`ifdef VME_SEQ_TIMEOUT_EN
    assign timeout_err        = tmo_err_q;
`else
    assign timeout_err        = 1'b0;
`endif

    logic unused_cfg;
    assign unused_cfg = ^{vme.vme_dat_reg_out, TIMEOUT};
endmodule
